// File: rtl/pool_feeder.sv
// pool_feeder: streams 1x2 pixel pairs, one channel group at a time, from feature memory to a pool engine.
// Define POOL_FEED_MASK_EN to zero lanes beyond the channel count in the last group.
module pool_feeder #(
  parameter int DATA_WIDTH       = 16,
  parameter int POOL_PARALLELISM = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [7:0]                                 input_size,
  input  logic [7:0]                                 channel,
  output logic                                       mem_en,
  output logic [15:0]                                mem_addr,
  input  logic [DATA_WIDTH*POOL_PARALLELISM-1:0]     mem_rdata,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH*POOL_PARALLELISM*2-1:0]   infeature,
  output logic [7:0]                                 out_h,
  output logic [7:0]                                 out_w,
  output logic [7:0]                                 out_grp,
  output logic                                       busy,
  output logic                                       done
);
  localparam int P  = POOL_PARALLELISM;
  localparam int DW = DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, SEND, FIN} state_e;
  state_e state_q, state_d;
  logic [7:0] size_q, size_d, grp_q, grp_d, h_q, h_d, w_q, w_d, g_q, g_d;
  logic [DW*P-1:0] a_q, a_d, b_q, b_d;
  logic [7:0] groups_in;
  logic h_last, w_last, g_last;
  logic [15:0] addr;
  assign groups_in = 8'((9'(channel) + 9'(P - 1)) / 9'(P));
  assign h_last = h_q == size_q - 8'd1;
  assign w_last = w_q == (size_q >> 1) - 8'd1;
  assign g_last = g_q == grp_q - 8'd1;
  // column is 2*w for pixel A and 2*w+1 for pixel B (read in RD_B)
  assign addr = (16'(h_q) * 16'(size_q) + 16'({w_q, state_q == RD_B})) * 16'(grp_q) + 16'(g_q);
  assign mem_en = state_q == RD_A || state_q == RD_B;
  assign mem_addr = mem_en ? addr : '0;
  assign out_valid = state_q == SEND;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign out_h = h_q;
  assign out_w = w_q;
  assign out_grp = g_q;
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    grp_d = grp_q;
    h_d = h_q;
    w_d = w_q;
    g_d = g_q;
    a_d = a_q;
    b_d = b_q;
    case (state_q)
      IDLE: if (start) begin
        size_d = input_size;
        grp_d = groups_in;
        h_d = '0;
        w_d = '0;
        g_d = '0;
        state_d = (input_size < 8'd2 || channel == 8'd0) ? FIN : RD_A;
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d = mem_rdata;
        state_d = CAP;
      end
      CAP: begin
        b_d = mem_rdata;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        g_d = g_last ? '0 : g_q + 8'd1;
        w_d = g_last ? (w_last ? '0 : w_q + 8'd1) : w_q;
        h_d = (g_last && w_last) ? (h_last ? '0 : h_q + 8'd1) : h_q;
        state_d = (g_last && w_last && h_last) ? FIN : RD_A;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q <= '0;
      grp_q <= '0;
      h_q <= '0;
      w_q <= '0;
      g_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      grp_q <= grp_d;
      h_q <= h_d;
      w_q <= w_d;
      g_q <= g_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
`ifdef POOL_FEED_MASK_EN
  logic [7:0] ch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_q <= '0;
    else if (state_q == IDLE && start) ch_q <= channel;
  end
  for (genvar i = 0; i < P; i++) begin : g_lane
    logic keep;
    assign keep = (32'(g_q) * P + i) < 32'(ch_q);
    assign infeature[2*DW*i +: 2*DW] = keep ? {b_q[DW*i +: DW], a_q[DW*i +: DW]} : '0;
  end
`else
  for (genvar i = 0; i < P; i++) begin : g_lane
    assign infeature[2*DW*i +: 2*DW] = {b_q[DW*i +: DW], a_q[DW*i +: DW]};
  end
`endif
endmodule

// File: tb/tb_pool_feeder.sv
// tb_pool_feeder: directed scoreboard bench for pool_feeder (addresses, pairs, timing, stall, reset).
module tb_pool_feeder;
`ifdef POOL_FEED_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  typedef struct {
    logic [7:0] h, w, g;
    logic [255:0] feat;
  } pair_t;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [7:0] input_size = '0, channel = '0;
  logic mem_en, out_valid, busy, done;
  logic [15:0] mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [255:0] infeature;
  logic [7:0] out_h, out_w, out_grp;
  int vectors = 0, errs = 0;
  int exp_addr[$];
  pair_t exp_pair[$];
  pool_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .input_size(input_size), .channel(channel),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .infeature(infeature), .out_h(out_h), .out_w(out_w),
    .out_grp(out_grp), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] word(input logic [15:0] a);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = {a[11:0], 4'(i)};
    return r;
  endfunction
  always @(posedge clk) mem_rdata <= mem_en ? word(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
  function automatic logic [255:0] feat(input int a, input int b, input int g, input int ch);
    logic [127:0] wa, wb;
    logic [255:0] r;
    wa = word(16'(a));
    wb = word(16'(b));
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = {wb[16*i +: 16], wa[16*i +: 16]};
      if (MASK && g * 8 + i >= ch) r[32*i +: 32] = '0;
    end
    return r;
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_pass(input int sz, input int ch, input bit stall);
    int groups, np, done_n, done_cnt, stall_left;
    bit pulsed;
    logic [255:0] snap_f;
    logic [23:0] snap_p;
    pair_t p;
    exp_addr.delete();
    exp_pair.delete();
    groups = (ch + 7) / 8;
    np = 0;
    if (sz >= 2 && ch != 0)
      for (int h = 0; h < sz; h++)
        for (int w = 0; w < sz / 2; w++)
          for (int g = 0; g < groups; g++) begin
            int a, b;
            a = ((h * sz + 2 * w) * groups + g) & 'hFFFF;
            b = ((h * sz + 2 * w + 1) * groups + g) & 'hFFFF;
            exp_addr.push_back(a);
            exp_addr.push_back(b);
            p.h = 8'(h);
            p.w = 8'(w);
            p.g = 8'(g);
            p.feat = feat(a, b, g, ch);
            exp_pair.push_back(p);
            np++;
          end
    out_ready = !stall;
    stall_left = 6;
    pulsed = 1'b0;
    done_n = 0;
    done_cnt = 0;
    snap_f = '0;
    snap_p = '0;
    @(negedge clk);
    start = 1'b1;
    input_size = 8'(sz);
    channel = 8'(ch);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1 || pulsed) start = 1'b0;
      if (mem_en) begin
        if (exp_addr.size() == 0) check("addr_extra", 1, 0);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (out_valid && !out_ready) begin
        if (stall_left == 6) begin
          snap_f = infeature;
          snap_p = {out_h, out_w, out_grp};
          start = 1'b1;
          input_size = 8'd2;
          pulsed = 1'b1;
        end else begin
          check("stall_feat", infeature, snap_f);
          check("stall_pos", {out_h, out_w, out_grp}, snap_p);
        end
        check("stall_mem_en", mem_en, 0);
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_pair.size() == 0) check("pair_extra", 1, 0);
        else begin
          p = exp_pair.pop_front();
          check("pair_pos", {out_h, out_w, out_grp}, {p.h, p.w, p.g});
          check("pair_feat", infeature, p.feat);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_n = n;
      end
      if (done_n != 0 && n == done_n + 1) begin
        check("done_pulse", done_cnt, 1);
        check("idle_busy", busy, 0);
        break;
      end
      if (n == 3000) check("timeout", 0, 1);
    end
    check("addrs_left", exp_addr.size(), 0);
    check("pairs_left", exp_pair.size(), 0);
    check("done_cycle", done_n, 4 * np + 1 + (stall ? 5 : 0));
    out_ready = 1'b1;
  endtask
  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_feat", infeature, 0);
    check("rst_pos", {out_h, out_w, out_grp}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_pass(4, 8, 1'b0);
    run_pass(4, 16, 1'b0);
    run_pass(5, 8, 1'b0);
    run_pass(4, 12, 1'b1);
    run_pass(1, 8, 1'b0);
    run_pass(4, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    input_size = 8'd4;
    channel = 8'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rdb_mem_en", mem_en, 1);
    check("rdb_addr", mem_addr, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_feat", infeature, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_pass(2, 8, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
